btn_scan_ctrl: RTL and testbench



---
 rtl/btn_scan_pkg.sv | 29 ++
 rtl/btn_scan_ctrl_rr_pick.sv | 37 +++
 rtl/btn_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_btn_scan_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_scan_pkg.sv
// -----------------------------------------------------------------------------
// btn_scan_pkg
// Shared definitions for the time-shared button debouncer:
//   state_t    - scheduler FSM states (IDLE, TRACK, COMMIT)
//   clog2      - ceiling log2, usable in constant expressions
//   sel_width  - width of a channel index for a given channel count (>= 1)
// -----------------------------------------------------------------------------
package btn_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/btn_scan_ctrl_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin first-one finder. Searches req starting at ptr and
// wrapping (ptr, ptr+1, ..., N-1, 0, ..., ptr-1); reports the first set bit.
// Ports:
//   req   in  N  request vector
//   ptr   in  W  search start index (must be < N)
//   valid out 1  at least one request is set
//   idx   out W  index of the winning request (ptr when valid = 0)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop, so no path
        // through this block leaves a value unassigned and no latch is inferred.
        valid = 1'b0;
        idx   = ptr;
        for (int k = 0; k < N; k++) begin
            int c;
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            if (!valid && req[c]) begin
                valid = 1'b1;
                idx   = W'(c);
            end
        end
    end

endmodule

// File: rtl/btn_scan_ctrl.sv
// -----------------------------------------------------------------------------
// btn_scan_ctrl
// Debounces N_BTN push buttons with one shared settle counter. Synchronized
// levels are compared against the committed clean state; a round-robin
// scheduler grants the counter to one mismatching channel, and the change is
// committed only after the new level holds for 2^CNT_W consecutive cycles.
// Ports:
//   clk      in  1      system clock
//   rst_n    in  1      asynchronous active-low reset
//   dirty    in  N_BTN  raw asynchronous button pins
//   clean    out N_BTN  debounced level, 1 = pressed (polarity-normalized)
//   press    out N_BTN  one-cycle pulse when clean[i] goes 0->1
//   released out N_BTN  one-cycle pulse when clean[i] goes 1->0
//                       ("release" is a reserved word in SystemVerilog)
//   busy     out 1      counter granted (state != IDLE)
//   sel      out SEL_W  channel currently or last granted
// -----------------------------------------------------------------------------
module btn_scan_ctrl
    import btn_scan_pkg::*;
#(
    parameter  int N_BTN      = 4,
    parameter  int CNT_W      = 16,
    parameter  bit ACTIVE_LOW = 1'b1,
    localparam int SEL_W      = sel_width(N_BTN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] dirty,
    output logic [N_BTN-1:0] clean,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] released,
    output logic             busy,
    output logic [SEL_W-1:0] sel
);

    logic [N_BTN-1:0] lvl;
    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [N_BTN-1:0] mismatch;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] next_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_valid;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    // Normalize so that 1 always means "pressed" from here on.
    assign lvl      = dirty ^ {N_BTN{ACTIVE_LOW}};
    assign mismatch = sync2 ^ clean;

    // Channel after the granted one, wrapping at N_BTN (which need not be a
    // power of two).
    assign next_ptr = (sel == SEL_W'(N_BTN - 1)) ? '0 : sel + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            // NOTE: non-blocking assignments let sync2 take the old sync1,
            // forming two real flops rather than collapsing into one.
            sync1 <= lvl;
            sync2 <= sync1;
        end
    end

    rr_pick #(
        .N (N_BTN),
        .W (SEL_W)
    ) u_rr_pick (
        .req   (mismatch),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            sel      <= '0;
            ptr      <= '0;
            cnt      <= '0;
            clean    <= '0;
            press    <= '0;
            released <= '0;
        end else begin
            // Event pulses only live for the cycle after a commit.
            press    <= '0;
            released <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        sel   <= pick_idx;
                        cnt   <= '0;
                        state <= TRACK;
                        busy  <= 1'b1;
                    end
                end
                TRACK: begin
                    if (!mismatch[sel]) begin
                        // Bounced back: give up the counter and move past
                        // this channel so it cannot monopolize the scan.
                        ptr   <= next_ptr;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (&cnt) begin
                        state <= COMMIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                COMMIT: begin
                    clean[sel]    <= ~clean[sel];
                    press[sel]    <= ~clean[sel];
                    released[sel] <= clean[sel];
                    ptr           <= next_ptr;
                    state         <= IDLE;
                    busy          <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_btn_scan_ctrl
// Self-checking bench for btn_scan_ctrl (N_BTN=4, CNT_W=4, ACTIVE_LOW=1).
// A cycle-level reference model, built from the scheduling rules in terms of
// an owning channel and a count of tracked cycles, is compared against every
// output after every clock. Directed scenarios additionally check event
// timing against fixed cycle counts; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_btn_scan_ctrl;

    localparam int N      = 4;
    localparam int CW     = 4;
    localparam int SETTLE = 1 << CW;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] dirty;
    logic [N-1:0] clean;
    logic [N-1:0] press;
    logic [N-1:0] released;
    logic         busy;
    logic [1:0]   sel;

    btn_scan_ctrl #(
        .N_BTN      (N),
        .CNT_W      (CW),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dirty    (dirty),
        .clean    (clean),
        .press    (press),
        .released (released),
        .busy     (busy),
        .sel      (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state.
    logic [N-1:0] m_s1, m_s2, m_clean, m_press, m_rel;
    int           m_owner;   // granted channel, -1 when nobody owns the counter
    int           m_ptr;
    int           m_sel;
    int           m_held;    // tracked cycles the owner has held its new level
    bit           m_commit;

    // Event log for directed timing checks.
    int n_press [N];
    int n_rel   [N];
    int last_press [N];
    int last_rel   [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_clean = '0; m_press = '0; m_rel = '0;
        m_owner = -1; m_ptr = 0; m_sel = 0; m_held = 0; m_commit = 0;
    endtask

    // One clock of the scheduling rules, evaluated on pre-edge values.
    task automatic model_step();
        logic [N-1:0] mis;
        mis = m_s2 ^ m_clean;
        m_press = '0;
        m_rel   = '0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && mis[c]) begin
                    m_owner = c;
                    m_sel   = c;
                    m_held  = 0;
                end
            end
        end else if (m_commit) begin
            if (m_clean[m_owner]) m_rel[m_owner] = 1'b1;
            else                  m_press[m_owner] = 1'b1;
            m_clean[m_owner] = ~m_clean[m_owner];
            m_ptr    = (m_owner + 1) % N;
            m_owner  = -1;
            m_commit = 0;
        end else if (!mis[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else begin
            m_held++;
            if (m_held == SETTLE) m_commit = 1;
        end
        m_s2 = m_s1;
        m_s1 = ~dirty;
    endtask

    task automatic compare_all();
        check("clean",   32'(clean),    32'(m_clean));
        check("press",   32'(press),    32'(m_press));
        check("release", 32'(released), 32'(m_rel));
        check("busy",    32'(busy),     32'(m_owner >= 0));
        check("sel",     32'(sel),      32'(m_sel));
    endtask

    task automatic clear_events();
        for (int i = 0; i < N; i++) begin
            n_press[i] = 0; n_rel[i] = 0; last_press[i] = -1; last_rel[i] = -1;
        end
    endtask

    // Advance one clock; inputs change only at the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) model_step();
        else       model_reset();
        @(negedge clk);
        compare_all();
        for (int i = 0; i < N; i++) begin
            if (press[i])    begin n_press[i]++; last_press[i] = cyc; end
            if (released[i]) begin n_rel[i]++;   last_rel[i]   = cyc; end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        ticks(3);
        rst_n = 1'b1;
    endtask

    initial begin
        int t0;
        int t1;
        int nlow;
        int sum;

        rst_n = 1'b0;
        dirty = '0;
        model_reset();
        clear_events();

        // Reset state with all pins asserted (pressed).
        ticks(3);
        check("rst_clean", 32'(clean), 32'h0);
        check("rst_press", 32'(press | released), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        dirty = 4'hF;
        rst_n = 1'b1;
        ticks(50);
        sum = 0;
        for (int i = 0; i < N; i++) sum += n_press[i] + n_rel[i];
        check("idle_no_pulses", 32'(sum), 32'd0);

        // Clean press and release on channel 1.
        clear_events();
        t0 = cyc;
        dirty[1] = 1'b0;
        ticks(19);
        check("press1_early", 32'(clean[1]), 32'd0);
        ticks(11);
        check("press1_count", 32'(n_press[1]), 32'd1);
        check("press1_lat",   32'(last_press[1] - t0), 32'd20);
        check("press1_clean", 32'(clean[1]), 32'd1);
        t1 = cyc;
        dirty[1] = 1'b1;
        ticks(30);
        check("rel1_count", 32'(n_rel[1]), 32'd1);
        check("rel1_lat",   32'(last_rel[1] - t1), 32'd20);

        // Bouncing on channel 2, then a final settled press.
        clear_events();
        for (int b = 0; b < 12; b++) begin
            dirty[2] = ~dirty[2];
            ticks(5);
        end
        check("bounce_quiet", 32'(n_press[2] + n_rel[2]), 32'd0);
        t0 = cyc;
        dirty[2] = 1'b0;
        ticks(30);
        check("bounce_count", 32'(n_press[2]), 32'd1);
        check("bounce_lat",   32'(last_press[2] - t0), 32'd20);
        dirty[2] = 1'b1;
        ticks(30);

        // Contention: channels 0 and 3 together from ptr = 0.
        do_reset();
        clear_events();
        nlow = 0;
        t0 = cyc;
        dirty[0] = 1'b0;
        dirty[3] = 1'b0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (cyc - t0 >= 3 && cyc - t0 <= 37 && !busy) nlow++;
        end
        check("cont_lat0",  32'(last_press[0] - t0), 32'd20);
        check("cont_lat3",  32'(last_press[3] - t0), 32'd38);
        check("cont_gap",   32'(nlow), 32'd1);
        dirty = 4'hF;
        ticks(60);

        // Starvation: channel 1 bounces forever, channel 2 must still commit.
        clear_events();
        t0 = cyc;
        dirty[2] = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (i % 3 == 0) dirty[1] = ~dirty[1];
            tick();
        end
        check("starve_count", 32'(n_press[2]), 32'd1);
        check("starve_bound", 32'((last_press[2] - t0) <= 20 + 2 * (SETTLE + 2)), 32'd1);
        check("starve_ch1",   32'(n_press[1]), 32'd0);
        dirty = 4'hF;
        ticks(40);

        // Asynchronous reset in the middle of tracking channel 0.
        do_reset();
        clear_events();
        dirty[0] = 1'b0;
        ticks(13);
        check("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_clean", 32'(clean), 32'h0);
        check("mid_busy",  32'(busy),  32'h0);
        check("mid_press", 32'(press), 32'h0);
        ticks(2);
        rst_n = 1'b1;
        t1 = cyc;
        ticks(30);
        check("mid_count", 32'(n_press[0]), 32'd1);
        check("mid_lat",   32'(last_press[0] - t1), 32'd20);

        // Randomized phase: slow toggles with occasional short glitches.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 39) == 0) dirty[b] = ~dirty[b];
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
